// File: rtl/ps2_scan_fifo_if.sv
// PS/2 front-end bus: raw keyboard lines, CPU pop request, and the
// memory-mapped status/scancode word with the frame error strobe.
interface ps2_scan_fifo_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic        rd_req;
  logic [31:0] kbd_word;
  logic        frame_err;

  // Keyboard/CPU side: drives the raw lines and the pop request.
  modport master (
    output ps2_clk,
    output ps2_data,
    output rd_req,
    input  kbd_word,
    input  frame_err
  );

  // Front-end side: consumes the raw lines, publishes the word.
  modport slave (
    input  ps2_clk,
    input  ps2_data,
    input  rd_req,
    output kbd_word,
    output frame_err
  );
endinterface

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard front end: synchronises and filters the PS/2 lines,
// deserialises 11-bit frames, folds E0/F0 prefixes into tagged entries,
// buffers them in a small FIFO and exposes the head as a 32-bit word.
module ps2_scan_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic          clk100mhz,
  input  logic          rst,
  ps2_scan_fifo_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------
  // Input synchronisers and glitch filter
  // ---------------------------------------------------------------
  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          clk_s;
  logic          dat_s;
  logic          filt_q;
  logic          filt_prev_q;
  logic [FW-1:0] filt_cnt_q;
  logic          sample;

  assign clk_s  = clk_sync_q[1];
  assign dat_s  = dat_sync_q[1];
  // A sample event is the falling edge of the filtered PS/2 clock.
  assign sample = filt_prev_q & ~filt_q;

  // Two-flop synchronisers; idle PS/2 lines are high.
  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
      dat_sync_q <= {dat_sync_q[0], bus.ps2_data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s != filt_q) begin
        if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q     <= clk_s;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Frame deserialiser
  // ---------------------------------------------------------------
  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [TW-1:0] tmo_q;
  logic          byte_done_q;
  logic          frame_err_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          tmo_hit;
  logic          frame_good;

  // The counter is held clear on sample events, so a timeout can only
  // fire in a cycle with no sample event.
  assign tmo_hit    = (state_q != S_IDLE) && !sample &&
                      (tmo_q == TW'(TIMEOUT_CYC - 1));
  // Odd parity over data plus parity bit, and a high stop bit.
  assign frame_good = dat_s && (^{shift_q, par_q});

  // Frame FSM with timeout abort; byte_done/frame_err are one-cycle pulses.
  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q == S_IDLE || sample) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (tmo_hit) begin
        state_q     <= S_IDLE;
        frame_err_q <= 1'b1;
      end else if (sample) begin
        case (state_q)
          S_IDLE: begin
            if (!dat_s) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end
          S_PARITY: begin
            state_q <= S_STOP;
          end
          S_STOP: begin
            if (frame_good) begin
              byte_done_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Data bits shift in LSB first; the byte stays put until the next frame.
  always_ff @(posedge clk100mhz) begin
    if (sample && state_q == S_DATA) begin
      shift_q <= {dat_s, shift_q[7:1]};
    end
    if (sample && state_q == S_PARITY) begin
      par_q <= dat_s;
    end
  end

  // ---------------------------------------------------------------
  // Prefix decode
  // ---------------------------------------------------------------
  logic       ext_pend_q;
  logic       brk_pend_q;
  logic       push;
  logic [9:0] entry;

  // Only real scancodes become entries; prefixes and 00/FF do not.
  always_comb begin
    push  = 1'b0;
    entry = {ext_pend_q, brk_pend_q, shift_q};
    if (byte_done_q) begin
      case (shift_q)
        8'hE0, 8'hF0, 8'h00, 8'hFF: push = 1'b0;
        default:                    push = 1'b1;
      endcase
    end
  end

  // Pending E0/F0 flags; a timeout abort drops them with the partial frame.
  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else if (tmo_hit) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else if (byte_done_q) begin
      case (shift_q)
        8'hE0: ext_pend_q <= 1'b1;
        8'hF0: brk_pend_q <= 1'b1;
        default: begin
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Entry FIFO and output word
  // ---------------------------------------------------------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          rd_prev_q;
  logic [31:0]   kbd_q;

  logic          rd_rise;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_d;
  logic [CW-1:0] cnt_d;
  logic          ovf_d;
  logic [9:0]    head_d;
  logic [31:0]   kbd_d;

  assign rd_rise = bus.rd_req & ~rd_prev_q;
  assign full    = (cnt_q == CW'(FIFO_DEPTH));

  // Next FIFO state and the word it will present; the word is built from
  // next-state values so it is valid one cycle after a push or pop.
  always_comb begin
    pop      = rd_rise && (cnt_q != '0);
    // When full, a push only lands if a pop frees the head slot this cycle.
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);
    ovf_d    = ovf_q;
    if (pop) begin
      ovf_d = 1'b0;
    end else if (push && full) begin
      ovf_d = 1'b1;
    end
    // The new entry becomes the head when it lands in the slot read next.
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      head_d = entry;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    kbd_d = {(cnt_d != '0), ovf_d, 10'd0, 4'(cnt_d), 6'd0,
             (cnt_d != '0) ? head_d : 10'd0};
  end

  // FIFO control, rd_req edge detect and the registered output word.
  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rd_prev_q <= 1'b0;
      kbd_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rd_prev_q <= bus.rd_req;
      kbd_q     <= kbd_d;
    end
  end

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk100mhz) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  assign bus.kbd_word  = kbd_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Bench for ps2_scan_fifo: directed scenarios followed by randomized frames,
// all compared against a queue-based model of the prefix/FIFO rules.
// The PS/2 clock is scaled to a 100-cycle bit period and the timeout to
// 1000 cycles so the run stays short.
module tb_ps2_scan_fifo;
  localparam int FD   = 8;
  localparam int FL   = 8;
  localparam int TO   = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_scan_fifo_if bus ();

  ps2_scan_fifo #(
    .FIFO_DEPTH (FD),
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk100mhz(clk),
    .rst      (rst),
    .bus      (bus)
  );

  int nchk  = 0;
  int nfail = 0;

  // frame_err pulse monitor
  int   err_hi   = 0;
  int   err_rise = 0;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_hi++;
    if (bus.frame_err === 1'b1 && err_prev !== 1'b1) err_rise++;
    err_prev = bus.frame_err;
  end

  // Reference model
  logic [9:0] mq[$];
  bit m_ovf, m_ext, m_brk;

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = '0;
    w[30] = m_ovf;
    if (mq.size() != 0) begin
      w[31]    = 1'b1;
      w[19:16] = 4'(mq.size());
      w[9:0]   = mq[0];
    end
    return w;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (b != 8'h00 && b != 8'hFF) begin
        if (mq.size() == FD) m_ovf = 1'b1;
        else mq.push_back({m_ext, m_brk, b});
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One PS/2 bit: data set while clock high, then a 50-cycle low phase.
  task automatic ps2_bit(input logic d);
    @(posedge clk);
    bus.ps2_data = d;
    wait_cyc(20);
    bus.ps2_clk = 1'b0;
    wait_cyc(50);
    bus.ps2_clk = 1'b1;
    wait_cyc(30);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop_bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ par_bad);
    ps2_bit(~stop_bad);
    bus.ps2_data = 1'b1;
    wait_cyc(40);
    if (!par_bad && !stop_bad) model_byte(b);
    @(negedge clk);
  endtask

  task automatic pop();
    @(posedge clk);
    bus.rd_req = 1'b1;
    wait_cyc(4);
    bus.rd_req = 1'b0;
    wait_cyc(4);
    if (mq.size() != 0) begin
      void'(mq.pop_front());
      m_ovf = 1'b0;
    end
    @(negedge clk);
  endtask

  // Hang guard
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, h0;
    logic [31:0] w0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rd_req   = 1'b0;
    model_reset();
    rst = 1'b1;
    wait_cyc(5);
    @(negedge clk);
    check("reset_word", bus.kbd_word, 32'h0);
    check("reset_err", {31'd0, bus.frame_err}, 32'h0);
    rst = 1'b0;
    wait_cyc(20);
    @(negedge clk);

    // 1: single good frame, then pop
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t1_frame", bus.kbd_word, 32'h8001_001C);
    check("t1_model", bus.kbd_word, model_word());
    pop();
    check("t1_pop", bus.kbd_word, 32'h0000_0000);

    // 2: prefix folding
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t2_brk", bus.kbd_word, 32'h8001_011C);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check("t2_two", bus.kbd_word, model_word());
    pop();
    check("t2_extbrk", bus.kbd_word, 32'h8001_0375);
    pop();
    check("t2_empty", bus.kbd_word, 32'h0);

    // 3: parity error -> one-cycle frame_err, nothing pushed
    e0 = err_rise;
    h0 = err_hi;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("t3_word", bus.kbd_word, 32'h0000_0000);
    check("t3_err_pulses", 32'(err_rise - e0), 32'd1);
    check("t3_err_width", 32'(err_hi - h0), 32'd1);

    // 3b: stop-bit error
    e0 = err_rise;
    send_frame(8'h2A, 1'b0, 1'b1);
    check("t3b_word", bus.kbd_word, 32'h0);
    check("t3b_err", 32'(err_rise - e0), 32'd1);

    // 4: overflow on the ninth push
    for (int i = 0; i < 9; i++) send_frame(8'(8'h15 + i), 1'b0, 1'b0);
    check("t4_full", bus.kbd_word, 32'hC008_0015);
    pop();
    check("t4_pop", bus.kbd_word, 32'h8007_0016);
    for (int i = 0; i < 7; i++) pop();
    check("t4_drain", bus.kbd_word, 32'h0);
    pop();
    check("t4_pop_empty", bus.kbd_word, 32'h0);

    // 5: timeout abort discards partial frame and a pending E0
    send_frame(8'hE0, 1'b0, 1'b0);
    e0 = err_rise;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    wait_cyc(TO + 200);
    m_ext = 1'b0;
    m_brk = 1'b0;
    @(negedge clk);
    check("t5_err", 32'(err_rise - e0), 32'd1);
    check("t5_nopush", bus.kbd_word, 32'h0);
    send_frame(8'h29, 1'b0, 1'b0);
    check("t5_next", bus.kbd_word, 32'h8001_0029);
    pop();

    // 6a: short glitch while idle is ignored
    e0 = err_rise;
    w0 = bus.kbd_word;
    @(posedge clk);
    bus.ps2_data = 1'b0;
    bus.ps2_clk  = 1'b0;
    wait_cyc(3);
    bus.ps2_clk  = 1'b1;
    wait_cyc(20);
    bus.ps2_data = 1'b1;
    wait_cyc(20);
    @(negedge clk);
    check("t6_glitch_word", bus.kbd_word, w0);
    check("t6_glitch_err", 32'(err_rise - e0), 32'd0);
    send_frame(8'h33, 1'b0, 1'b0);
    check("t6_after_glitch", bus.kbd_word, 32'h8001_0033);

    // 6b: reset mid-frame
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_word", bus.kbd_word, 32'h0);
    model_reset();
    wait_cyc(5);
    @(negedge clk);
    rst = 1'b0;
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    wait_cyc(TO + 200);
    @(negedge clk);
    check("t6_rst_leftover", bus.kbd_word, 32'h0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t6_rst_next", bus.kbd_word, 32'h8001_001C);

    // Randomized frames and pops against the model
    for (int i = 0; i < 18; i++) begin
      int unsigned sel;
      logic [7:0]  b;
      logic        pb, sb;
      sel = $urandom_range(0, 11);
      case (sel)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h00;
        3: b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      pb = ($urandom_range(0, 7) == 0);
      sb = !pb && ($urandom_range(0, 9) == 0);
      e0 = err_rise;
      send_frame(b, pb, sb);
      check($sformatf("rnd%0d_word", i), bus.kbd_word, model_word());
      check($sformatf("rnd%0d_err", i), 32'(err_rise - e0), 32'((pb || sb) ? 1 : 0));
      if ($urandom_range(0, 2) == 0) begin
        pop();
        check($sformatf("rnd%0d_pop", i), bus.kbd_word, model_word());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/ps2_scan_fifo.md
Name: ps2_scan_fifo

Overview:
PS/2 keyboard front end running on clk100mhz. It deserialises keyboard frames and folds the E0 (extended) and F0 (break) prefixes into tagged scancode entries. Entries are buffered in a small FIFO and presented as one 32-bit memory-mapped word to the CPU data-memory path. The CPU pops an entry by raising rd_req from its divided clock domain; the same word also drives the 8-digit display.

Parameters:
FIFO_DEPTH, 8, number of entries; power of 2, maximum 8.
FILTER_LEN, 8, consecutive equal samples needed before the filtered ps2_clk changes.
TIMEOUT_CYC, 20000, clk100mhz cycles without a falling edge before an in-progress frame is aborted (200 us).

Ports:
clk100mhz  in   1   system clock, 100 MHz
rst        in   1   reset, asynchronous, active-high
ps2_clk    in   1   raw PS/2 clock from keyboard, asynchronous
ps2_data   in   1   raw PS/2 data from keyboard, asynchronous
rd_req     in   1   pop request from CPU clock domain; each rising edge pops one entry
kbd_word   out  32  [31] non-empty, [30] overflow sticky, [19:16] entry count, [9] extended, [8] break, [7:0] scancode of head entry; all other bits 0
frame_err  out  1   one-cycle pulse on parity, stop-bit or timeout error

Behaviour:
- Input sync:
  - ps2_clk and ps2_data each pass through 2 flops; both reset to 1.
  - Filtered clock resets to 1. It changes only after FILTER_LEN consecutive synced samples differ from its current value.
  - A sample event is a 1->0 transition of the filtered clock. Data is taken from the synced ps2_data in that same cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a sample event with data=0, go to DATA and clear the bit counter. data=1 is ignored.
  - DATA: shift bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: the frame is good if data=1 and the total count of ones over the 8 data bits plus the parity bit is odd. A good frame asserts byte_done for one cycle; a bad frame pulses frame_err. Either way return to IDLE.
- Timeout:
  - A counter clears on every sample event and in IDLE.
  - In any other state, reaching TIMEOUT_CYC-1 forces IDLE, pulses frame_err, and discards the partial byte and any pending prefixes.
- Prefix decode (on byte_done):
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - 0x00 and 0xFF are dropped and clear both prefixes.
  - Any other byte pushes {ext_pend, brk_pend, byte} and clears both prefixes.
- FIFO:
  - Circular buffer with read pointer, write pointer and a count register.
  - A push happens one cycle after byte_done.
  - The rd_req rising edge is detected by a 1-flop delay compare. A pop happens in that cycle if count>0; a pop on empty is ignored.
  - Push while full with no pop: the entry is dropped and overflow is set.
  - Simultaneous push and pop: both take effect, count is unchanged and overflow is not set, even when full.
  - Simultaneous push and pop when empty: the pop is ignored and the push proceeds.
  - Overflow clears on any successful pop.
- Output:
  - kbd_word is registered and reflects the head entry and count one cycle after a push or pop.
  - When empty, bits [9:0] read 0.
- Reset:
  - kbd_word=0, frame_err=0, FSM in IDLE, FIFO empty, prefixes and overflow cleared.
  - Reset asserted mid-frame discards that frame. Any remaining bits after release are either rejected by parity/stop checking or aborted by timeout.
- Latency: kbd_word non-empty 2 cycles after the sample event of the stop bit, plus the filter and sync delay after the raw ps2_clk falling edge.

Test Plan:
1. Frame 0x1C with parity bit 0 and stop bit 1, 10 kHz PS/2 clock -> kbd_word=0x8001_001C. A rd_req rising edge -> 0x0000_0000.
2. Bytes F0,1C -> a single entry, kbd_word=0x8001_011C. Bytes E0,F0,75 -> a second entry. After popping the first, kbd_word=0x8001_0375.
3. Frame 0x1C sent with parity bit 1 -> one-cycle frame_err, kbd_word remains 0x0000_0000.
4. Nine bytes 0x15..0x1D sent with no reads -> kbd_word=0xC008_0015. After one pop -> 0x8007_0016 with the overflow bit cleared.
5. Start bit plus 4 data bits, then clock held high for more than TIMEOUT_CYC -> frame_err pulse, nothing pushed. The next frame 0x29 gives kbd_word=0x8001_0029.
6. A 3-cycle low glitch on ps2_clk while idle is ignored with no state change. rst asserted mid-frame gives kbd_word=0 immediately; the next clean 0x1C frame is received correctly.
